// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply-accumulate element for a FIOS processing element.
// Four modes: MUL, MULC, ACC, and ACCSH (accumulate with right shift), plus a carry-out bit.
module dsp_mac_pipe #(
  parameter int A_WIDTH = 17,
  parameter int B_WIDTH = 17,
  parameter int C_WIDTH = 34,
  parameter int P_WIDTH = 34,
  parameter int ABREG   = 1,
  parameter int MREG    = 1,
  parameter int SHIFT   = 17
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  input  logic [1:0]         mode_i,
  input  logic               C_en_i,
  input  logic [A_WIDTH-1:0] A_i,
  input  logic [B_WIDTH-1:0] B_i,
  input  logic [C_WIDTH-1:0] C_i,
  output logic               valid_o,
  output logic [P_WIDTH-1:0] P_o,
  output logic               carry_o
);

  if (ABREG < 0 || ABREG > 2 || MREG < 0 || MREG > 1 ||
      C_WIDTH > P_WIDTH || SHIFT < 0 || SHIFT >= P_WIDTH) begin : g_bad_params
    $error("dsp_mac_pipe: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    MODE_MUL   = 2'd0,
    MODE_MULC  = 2'd1,
    MODE_ACC   = 2'd2,
    MODE_ACCSH = 2'd3
  } mode_e;

  typedef struct packed {
    logic               valid;
    mode_e              mode;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [C_WIDTH-1:0] c;
  } op_t;

  typedef struct packed {
    logic               valid;
    mode_e              mode;
    logic [P_WIDTH-1:0] prod;
    logic [C_WIDTH-1:0] c;
  } mul_t;

  logic [C_WIDTH-1:0] c_hold;
  logic [C_WIDTH-1:0] c_eff;
  op_t                op_in;
  op_t                op_ab;
  mul_t               m_in;
  mul_t               m_out;
  logic [P_WIDTH:0]   sum;

  // c_hold follows c_eff on every edge, whether or not an operation issues.
  assign c_eff = C_en_i ? C_i : c_hold;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) c_hold <= '0;
    else            c_hold <= c_eff;
  end

  assign op_in = '{valid: valid_i, mode: mode_e'(mode_i), a: A_i, b: B_i, c: c_eff};

  if (ABREG == 0) begin : g_ab_bypass
    assign op_ab = op_in;
  end else begin : g_ab_regs
    op_t ab_q [ABREG];

    // NOTE: pipeline data registers are reset along with the valid bits.
    // Flushed ops then leave no stale operands behind after reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        for (int i = 0; i < ABREG; i++) ab_q[i] <= '0;
      end else begin
        ab_q[0] <= op_in;
        for (int i = 1; i < ABREG; i++) ab_q[i] <= ab_q[i-1];
      end
    end

    assign op_ab = ab_q[ABREG-1];
  end

  // Truncating both operands first gives the same result as truncating the full product.
  assign m_in = '{valid: op_ab.valid,
                  mode:  op_ab.mode,
                  prod:  P_WIDTH'(op_ab.a) * P_WIDTH'(op_ab.b),
                  c:     op_ab.c};

  if (MREG == 0) begin : g_m_bypass
    assign m_out = m_in;
  end else begin : g_m_reg
    mul_t m_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) m_q <= '0;
      else            m_q <= m_in;
    end

    assign m_out = m_q;
  end

  // NOTE: sum gets a default before the case, so no latch is inferred for it.
  always_comb begin
    sum = {1'b0, m_out.prod};
    case (m_out.mode)
      MODE_MULC:  sum = {1'b0, m_out.prod} + (P_WIDTH+1)'(m_out.c);
      MODE_ACC:   sum = {1'b0, m_out.prod} + {1'b0, P_o};
      MODE_ACCSH: sum = {1'b0, m_out.prod} + {1'b0, P_o >> SHIFT};
      default:    ;
    endcase
  end

  // P and carry change only on a completed op, so gaps in the op stream keep the last result.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o <= 1'b0;
      P_o     <= '0;
      carry_o <= 1'b0;
    end else begin
      valid_o <= m_out.valid;
      if (m_out.valid) {carry_o, P_o} <= sum;
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: directed scenarios plus randomized
// traffic. Three latencies (L = 3, 1, 4) are compared against an arithmetic model.
module tb_dsp_mac_pipe;

  logic        clock_i   = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        valid_i   = 1'b0;
  logic [1:0]  mode_i    = 2'd0;
  logic        C_en_i    = 1'b0;
  logic [16:0] A_i       = '0;
  logic [16:0] B_i       = '0;
  logic [33:0] C_i       = '0;

  logic [2:0]  dv;
  logic [2:0]  dc;
  logic [33:0] dp0, dp1, dp2;
  logic [33:0] dp [3];

  assign dp[0] = dp0;
  assign dp[1] = dp1;
  assign dp[2] = dp2;

  int checks = 0;
  int errors = 0;
  int lat [3] = '{3, 1, 4};

  always #5 clock_i = ~clock_i;

  dsp_mac_pipe dut_l3 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .mode_i(mode_i),
    .C_en_i(C_en_i), .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .valid_o(dv[0]), .P_o(dp0), .carry_o(dc[0])
  );

  dsp_mac_pipe #(.ABREG(0), .MREG(0)) dut_l1 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .mode_i(mode_i),
    .C_en_i(C_en_i), .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .valid_o(dv[1]), .P_o(dp1), .carry_o(dc[1])
  );

  dsp_mac_pipe #(.ABREG(2), .MREG(1)) dut_l4 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .mode_i(mode_i),
    .C_en_i(C_en_i), .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .valid_o(dv[2]), .P_o(dp2), .carry_o(dc[2])
  );

  // Reference model. Each edge records the issued op with its effective C.
  // For each latency, the op sampled L-1 edges ago is folded into that
  // configuration's accumulator using plain integer arithmetic.
  typedef struct {
    bit          v;
    logic [1:0]  mode;
    logic [16:0] a;
    logic [16:0] b;
    logic [33:0] c;
  } iss_t;

  iss_t        hist [$];
  logic [33:0] m_chold;
  logic [33:0] m_p [3];
  bit          m_c [3];
  bit          m_v [3];

  always @(posedge clock_i or negedge reset_n_i) begin : model
    iss_t            op;
    logic [33:0]     ce;
    longint unsigned pr;
    longint unsigned s;
    if (!reset_n_i) begin
      hist.delete();
      m_chold <= '0;
      for (int k = 0; k < 3; k++) begin
        m_p[k] <= '0;
        m_c[k] <= 1'b0;
        m_v[k] <= 1'b0;
      end
    end else begin
      ce = C_en_i ? C_i : m_chold;
      m_chold <= ce;
      op = '{v: valid_i, mode: mode_i, a: A_i, b: B_i, c: ce};
      hist.push_front(op);
      if (hist.size() > 8) void'(hist.pop_back());
      for (int k = 0; k < 3; k++) begin
        if (hist.size() >= lat[k] && hist[lat[k]-1].v) begin
          op = hist[lat[k]-1];
          pr = (64'(op.a) * 64'(op.b)) % (64'd1 << 34);
          case (op.mode)
            2'd0:    s = pr;
            2'd1:    s = pr + 64'(op.c);
            2'd2:    s = pr + 64'(m_p[k]);
            default: s = pr + (64'(m_p[k]) >> 17);
          endcase
          m_p[k] <= s[33:0];
          m_c[k] <= s[34];
          m_v[k] <= 1'b1;
        end else begin
          m_v[k] <= 1'b0;
        end
      end
    end
  end

  task automatic idle();
    valid_i = 1'b0;
    mode_i  = 2'd0;
    C_en_i  = 1'b0;
    A_i     = '0;
    B_i     = '0;
    C_i     = '0;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [16:0] a,
                       input logic [16:0] b, input logic [33:0] c, input logic cen);
    valid_i = v;
    mode_i  = m;
    A_i     = a;
    B_i     = b;
    C_i     = c;
    C_en_i  = cen;
  endtask

  task automatic test_reset();
    #2 reset_n_i = 1'b0;
    @(negedge clock_i);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dv[k], dp[k], dc[k]} !== 36'd0) begin
        errors++;
        $display("FAIL reset_hold dut%0d got v=%b p=%h c=%b exp all zero", k, dv[k], dp[k], dc[k]);
      end
    end
    @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (3) begin
      @(negedge clock_i);
      checks++;
      if (dv !== 3'b000) begin
        errors++;
        $display("FAIL reset_release valid got %b exp 000", dv);
      end
    end
  endtask

  task automatic test_mul_max();
    drive(1'b1, 2'd0, 17'h1FFFF, 17'h1FFFF, 34'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock_i);
      idle();
      checks++;
      if (dv[0] !== 1'(i == 3)) begin
        errors++;
        $display("FAIL mul_max valid step%0d got %b exp %b", i, dv[0], i == 3);
      end
      if (i == 3) begin
        checks++;
        if (dp[0] !== 34'h3FFFC0001 || dc[0] !== 1'b0) begin
          errors++;
          $display("FAIL mul_max result got p=%h c=%b exp p=3fffc0001 c=0", dp[0], dc[0]);
        end
      end
    end
  endtask

  task automatic test_mulc_overflow();
    drive(1'b1, 2'd1, 17'h1FFFF, 17'h1FFFF, 34'h3FFFFFFFF, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock_i);
      idle();
      checks++;
      if (dv[0] !== 1'(i == 3)) begin
        errors++;
        $display("FAIL mulc_ovf valid step%0d got %b exp %b", i, dv[0], i == 3);
      end
      if (i == 3) begin
        checks++;
        if (dp[0] !== 34'h3FFFC0000 || dc[0] !== 1'b1) begin
          errors++;
          $display("FAIL mulc_ovf result got p=%h c=%b exp p=3fffc0000 c=1", dp[0], dc[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_p;
    drive(1'b1, 2'd0, 17'h1FFFF, 17'h1FFFF, 34'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock_i);
      if (i == 1) drive(1'b1, 2'd3, 17'd2, 17'd3, 34'd0, 1'b0);
      else        idle();
      checks++;
      if (dv[0] !== 1'(i == 3 || i == 4)) begin
        errors++;
        $display("FAIL b2b_accsh valid step%0d got %b exp %b", i, dv[0], i == 3 || i == 4);
      end
      if (i == 3 || i == 4) begin
        exp_p = (i == 3) ? 34'h3FFFC0001 : 34'h0000_20004;
        checks++;
        if (dp[0] !== exp_p || dc[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_accsh result step%0d got p=%h c=%b exp p=%h c=0", i, dp[0], dc[0], exp_p);
        end
      end
    end
  endtask

  task automatic test_c_hold();
    drive(1'b0, 2'd0, 17'd0, 17'd0, 34'd5, 1'b1);
    @(negedge clock_i);
    drive(1'b1, 2'd1, 17'd1, 17'd1, 34'h123, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock_i);
      idle();
      if (i == 3) begin
        checks++;
        if (dv[0] !== 1'b1 || dp[0] !== 34'd6 || dc[0] !== 1'b0) begin
          errors++;
          $display("FAIL c_hold result got v=%b p=%h c=%b exp v=1 p=6 c=0", dv[0], dp[0], dc[0]);
        end
      end
    end
  endtask

  task automatic test_bubble();
    logic [33:0] exp_p;
    drive(1'b1, 2'd0, 17'd7, 17'd9, 34'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock_i);
      if (i == 5) drive(1'b1, 2'd2, 17'd1, 17'd1, 34'd0, 1'b0);
      else        idle();
      checks++;
      if (dv[0] !== 1'(i == 3 || i == 8)) begin
        errors++;
        $display("FAIL bubble valid step%0d got %b exp %b", i, dv[0], i == 3 || i == 8);
      end
      if (i >= 3) begin
        exp_p = (i >= 8) ? 34'd64 : 34'd63;
        checks++;
        if (dp[0] !== exp_p) begin
          errors++;
          $display("FAIL bubble p step%0d got %0d exp %0d", i, dp[0], exp_p);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 2'd0, 17'($urandom_range(1, 'h1FFFF)), 17'($urandom_range(1, 'h1FFFF)), 34'd0, 1'b0);
      @(negedge clock_i);
    end
    idle();
    reset_n_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dv[k], dp[k], dc[k]} !== 36'd0) begin
        errors++;
        $display("FAIL midflight_async dut%0d got v=%b p=%h c=%b exp all zero", k, dv[k], dp[k], dc[k]);
      end
    end
    @(negedge clock_i);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock_i);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dv[k] !== 1'b0 || dp[k] !== 34'd0) begin
          errors++;
          $display("FAIL midflight_quiet dut%0d step%0d got v=%b p=%h exp v=0 p=0", k, i, dv[k], dp[k]);
        end
      end
    end
    // c_hold was cleared by reset, so MULC without a C load adds zero.
    drive(1'b1, 2'd1, 17'd3, 17'd5, 34'h3FF, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock_i);
      idle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dv[k] !== 1'(i == lat[k]) || (i >= lat[k] && dp[k] !== 34'd15)) begin
          errors++;
          $display("FAIL post_reset dut%0d step%0d got v=%b p=%0d exp v=%b p=15", k, i, dv[k], dp[k], i == lat[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock_i);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dv[k] !== m_v[k] || dp[k] !== m_p[k] || dc[k] !== m_c[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got v=%b p=%h c=%b exp v=%b p=%h c=%b",
                   k, i, dv[k], dp[k], dc[k], m_v[k], m_p[k], m_c[k]);
        end
      end
      if (i == 200) begin
        idle();
        reset_n_i = 1'b0;
      end else if (i == 201) begin
        idle();
        reset_n_i = 1'b1;
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 17'($urandom), 17'($urandom),
              {2'($urandom), 32'($urandom)}, 1'($urandom));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_max();
    test_mulc_overflow();
    test_back_to_back();
    test_c_hold();
    test_bubble();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, behavioural multiply-accumulate processing element. It is the next generation of the FIOS processing-element arithmetic wrapper, generalised in operand widths and pipeline depth. It adds per-operation mode selection, a valid pipeline, carry-out and a shifted-accumulate path for FIOS carry propagation. It sits inside each FIOS processing element, between the operand scheduling logic and the PE result register.

## Interface
- A_WIDTH, 17: width of unsigned multiplicand A.
- B_WIDTH, 17: width of unsigned multiplier B.
- C_WIDTH, 34: width of unsigned addend C (≤ P_WIDTH).
- P_WIDTH, 34: result width; all arithmetic is modulo 2^P_WIDTH.
- ABREG, 1: operand register stages, 0–2.
- MREG, 1: product register stages, 0–1.
- SHIFT, 17: right-shift amount for the ACCSH mode (< P_WIDTH).

Ports:
- clock_i, input, 1: single clock, rising edge.
- reset_n_i, input, 1: asynchronous active-low reset.
- valid_i, input, 1: issues one operation this cycle.
- mode_i, input, 2: operation select; 0 = MUL, 1 = MULC, 2 = ACC, 3 = ACCSH.
- C_en_i, input, 1: load C_i into the C hold register.
- A_i, input, A_WIDTH: multiplicand.
- B_i, input, B_WIDTH: multiplier.
- C_i, input, C_WIDTH: addend.
- valid_o, output, 1: P_o/carry_o updated by a completed operation.
- P_o, output, P_WIDTH: result register.
- carry_o, output, 1: bit P_WIDTH of the full-width sum, registered with P_o.

## Operation
- Reset (reset_n_i low, asynchronous): every register clears immediately. This includes the operand, product, mode, valid and C-hold pipelines and P/carry. Output values: valid_o = 0, P_o = 0, carry_o = 0.
- Effective C at issue: c_eff = C_en_i ? C_i : c_hold. The hold register updates c_hold <= c_eff every cycle.
- A, B, mode, c_eff and valid travel together through ABREG operand stages, MREG product stages and one P stage. prod = A*B is zero-extended, then truncated to P_WIDTH.
- At the P stage, with Pq the current P register value, the sum is computed at P_WIDTH+1 bits:
  - MUL: prod.
  - MULC: prod + c_eff.
  - ACC: prod + Pq.
  - ACCSH: prod + (Pq >> SHIFT), zero-filled.
- The P register updates only when the P-stage valid bit is 1. P <= sum[P_WIDTH-1:0] and carry <= sum[P_WIDTH].
- With the stage valid bit at 0, P and carry hold their values, and pipeline data in that stage is don't-care.
- The prior carry_o is never added back in by any mode.
- Dependency: ACC/ACCSH use the result of the immediately preceding completed operation, including back-to-back issues with no bubble. Each new accumulation chain starts with MUL or MULC.
- No stalls and no backpressure. One operation per cycle is sustained indefinitely.
- Operands not paired with valid_i = 1 never alter P_o or carry_o. C_en_i, however, always acts on c_hold regardless of valid_i.

## Timing
- Latency L = ABREG + MREG + 1 cycles. An op issued at rising edge t produces valid_o = 1 and the new P_o after edge t+L.
- valid_o is high for exactly one cycle per issued op. It is the valid_i stream delayed by L.
- With ABREG = 0 and MREG = 0, L = 1: A_i/B_i feed the multiplier combinationally into the P register.
- Reset release is synchronous to the first rising edge after reset_n_i goes high. No valid_o may appear until L edges after the first post-reset valid_i.
- Reset mid-operation: ops in flight are dropped, and none of them emerges after release.
- Legal parameter ranges: ABREG ∈ {0,1,2}, MREG ∈ {0,1}, C_WIDTH ≤ P_WIDTH, SHIFT < P_WIDTH. Elaboration fails on any value outside these ranges.

## Test plan
All scenarios use the default parameters (L = 3) unless noted.
- MUL max operands: A = B = 0x1FFFF, valid for 1 cycle -> after 3 edges, valid_o pulses 1 cycle with P_o = 0x3FFFC0001 and carry_o = 0.
- MULC overflow: A = B = 0x1FFFF, C_i = 0x3FFFFFFFF with C_en_i = 1 -> P_o = 0x3FFFC0000, carry_o = 1.
- Back-to-back ACCSH: issue MUL A = B = 0x1FFFF, then on the next cycle ACCSH with A = 2, B = 3 -> valid_o stays high 2 consecutive cycles with P_o = 0x3FFFC0001 then 0x20004.
- C hold: C_i = 5 with C_en_i = 1 (no op), then MULC A = 1, B = 1 with C_en_i = 0 and C_i = 0x123 -> P_o = 6.
- Bubble holds state: MUL A = 7, B = 9, then 4 idle cycles, then ACC A = 1, B = 1 -> P_o holds 63 during the idle cycles, then 64. valid_o is low except on the 2 result cycles.
- Reset mid-flight: issue 3 ops, assert reset_n_i low 1 cycle after the last issue, release 2 cycles later -> P_o = 0 and valid_o = 0 immediately, and no valid_o for 10 cycles afterwards. Repeat with ABREG = 0, MREG = 0 and ABREG = 2 to check L = 1 and L = 4.
